// File: rtl/mac_acc.sv
// mac_acc: K-term unsigned dot-product engine.
// Terms (A, X) enter through a valid/ready handshake, pass a two-stage
// pipeline (operand register, product register) and are summed into a
// W-bit accumulator. After K terms the pipeline drains and the sum is
// presented on out_sum with out_valid until the consumer takes it.

// mult_full: exact unsigned N x M multiplier, full N+M bit result.
module mult_full #(
   parameter int N = 8,
   parameter int M = 8
) (
   input  logic [N-1:0]   a,
   input  logic [M-1:0]   b,
   output logic [N+M-1:0] p
);

   // Operands are zero-extended to the result width so no bits are lost.
   always_comb begin
      p = {{M{1'b0}}, a} * {{N{1'b0}}, b};
   end

endmodule

// Handshake rules (both ports):
//   a transfer happens in exactly the cycles where valid and ready are both 1
//   at the rising edge; the producer holds its data stable while valid=1 and
//   ready=0; ready never depends on valid of the same port.
module mac_acc #(
   parameter  int N = 8,
   parameter  int M = N,
   parameter  int K = 4,
   localparam int W = N + M + $clog2(K)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [M-1:0] X,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         busy,
   output logic [1:0]   dbg_state
);

   localparam int KW = $clog2(K);
   localparam int PW = N + M;
   localparam logic [KW-1:0] LAST_TERM = KW'(K - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [KW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   a_q, a_d;
   logic [M-1:0]   x_q, x_d;
   logic           s1_v_q, s1_v_d;
   logic [PW-1:0]  prod_q, prod_d;
   logic           s2_v_q, s2_v_d;
   logic [W-1:0]   acc_q, acc_d;

   logic [PW-1:0]  prod_w;
   logic           take_in;
   logic           take_out;

   // Stage-1 operands feed the multiplier; its result lands in stage 2.
   mult_full #(
      .N (N),
      .M (M)
   ) u_mult (
      .a (a_q),
      .b (x_q),
      .p (prod_w)
   );

   // Handshake decode: ready comes only from state (and is forced low in reset).
   always_comb begin
      in_ready  = ((state_q == IDLE) || (state_q == ACC)) && !rst;
      out_valid = (state_q == DONE);
      take_in   = in_valid && in_ready;
      take_out  = out_valid && out_ready;
   end

   // Pipeline, accumulator and state machine next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      x_d     = x_q;
      prod_d  = prod_q;
      acc_d   = acc_q;

      // Stage 1: capture operands only on an accepted term.
      s1_v_d = take_in;
      if (take_in) begin
         a_d = A;
         x_d = X;
      end

      // Stage 2: capture the product one cycle after acceptance.
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
         prod_d = prod_w;
      end

      // Accumulator: a new batch starts from zero; otherwise sum valid products.
      // In IDLE the pipeline is always empty, so clear and add never collide.
      if ((state_q == IDLE) && take_in) begin
         acc_d = '0;
      end else if (s2_v_q) begin
         acc_d = acc_q + W'(prod_q);
      end

      unique case (state_q)
         IDLE: begin
            if (take_in) begin
               cnt_d   = KW'(1);
               state_d = ACC;
            end
         end
         ACC: begin
            if (take_in) begin
               if (cnt_q == LAST_TERM) begin
                  cnt_d   = '0;
                  state_d = DRAIN;
               end else begin
                  cnt_d = cnt_q + KW'(1);
               end
            end
         end
         DRAIN: begin
            // Once stage 1 is empty, the last product is either in stage 2
            // (and is summed at this edge) or already summed, so the
            // accumulator is final in the next cycle.
            if (!s1_v_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (take_out) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All state registers, with synchronous reset clearing everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         x_q     <= '0;
         s1_v_q  <= 1'b0;
         prod_q  <= '0;
         s2_v_q  <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         x_q     <= x_d;
         s1_v_q  <= s1_v_d;
         prod_q  <= prod_d;
         s2_v_q  <= s2_v_d;
         acc_q   <= acc_d;
      end
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      out_sum   = out_valid ? acc_q : '0;
      busy      = (state_q != IDLE);
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_mac_acc.sv
// tb_mac_acc: table-driven batches plus hand-written corner sequences for
// mac_acc (N=M=8, K=4). Expected sums go into exp_q when a batch is driven
// and are popped by a monitor when the result handshake happens.
module tb_mac_acc;

   localparam int N = 8;
   localparam int M = 8;
   localparam int K = 4;
   localparam int W = N + M + $clog2(K);

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  A;
   logic [M-1:0]  X;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          busy;
   logic [1:0]    dbg_state;

   mac_acc #(.N(N), .M(M), .K(K)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .X         (X),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   typedef struct packed {
      logic [3:0][7:0]  a;
      logic [3:0][7:0]  x;
      logic [3:0][1:0]  gap;
      logic [W-1:0]     exp_sum;
   } vec_t;

   vec_t          vecs[6];
   logic [W-1:0]  exp_q[$];
   int            checks;
   int            failures;
   int            cyc;
   int            last_acc_cyc;
   logic          prev_ov;

   // ---------------- clock / reset block ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic void check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic vec_t mk(input int a0, a1, a2, a3, input int x0, x1, x2, x3,
                               input int g0, g1, g2, g3, input int e);
      vec_t v;
      v.a[0] = 8'(a0); v.a[1] = 8'(a1); v.a[2] = 8'(a2); v.a[3] = 8'(a3);
      v.x[0] = 8'(x0); v.x[1] = 8'(x1); v.x[2] = 8'(x2); v.x[3] = 8'(x3);
      v.gap[0] = 2'(g0); v.gap[1] = 2'(g1); v.gap[2] = 2'(g2); v.gap[3] = 2'(g3);
      v.exp_sum = W'(e);
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   // Present one term and hold it until accepted; returns at posedge+1.
   task automatic send_term(input logic [7:0] a, input logic [7:0] x);
      logic ok;
      int   n;
      A = a;
      X = x;
      in_valid = 1'b1;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = in_ready;
         if (ok) last_acc_cyc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) check("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_timeout", exp_q.size(), 0);
   endtask

   // ---------------- scoreboard monitor ----------------
   initial prev_ov = 1'b0;
   always @(negedge clk) begin
      if (!out_valid) begin
         check("sum_zero_when_idle", out_sum, 0);
      end else begin
         if (!prev_ov) check("result_latency", cyc, last_acc_cyc + 3);
         check("in_ready_low_in_done", in_ready, 0);
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", out_sum, -1);
            end else begin
               check("out_sum", out_sum, exp_q.pop_front());
            end
         end else if (exp_q.size() != 0) begin
            check("held_sum", out_sum, exp_q[0]);
         end
      end
      prev_ov = out_valid;
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] s;
      checks = 0;
      failures = 0;
      last_acc_cyc = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      A = '0;
      X = '0;

      vecs[0] = mk(3, 2, 1, 0,   5, 7, 1, 9,         0, 0, 0, 0, 30);
      vecs[1] = mk(255, 255, 255, 255, 255, 255, 255, 255, 0, 0, 0, 0, 260100);
      vecs[2] = mk(3, 2, 1, 0,   5, 7, 1, 9,         1, 3, 2, 0, 30);
      vecs[3] = mk(0, 0, 0, 0,   0, 0, 0, 0,         0, 2, 0, 0, 0);
      for (int i = 4; i < 6; i++) begin
         s = '0;
         for (int j = 0; j < 4; j++) begin
            vecs[i].a[j]   = 8'($urandom_range(0, 255));
            vecs[i].x[j]   = 8'($urandom_range(0, 255));
            vecs[i].gap[j] = 2'($urandom_range(0, 3));
            s = s + W'(vecs[i].a[j]) * W'(vecs[i].x[j]);
         end
         vecs[i].exp_sum = s;
      end

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_busy", busy, 0);
      @(posedge clk);
      #1;

      // Table-driven batches.
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(vecs[i].exp_sum);
         for (int j = 0; j < 4; j++) begin
            send_term(vecs[i].a[j], vecs[i].x[j]);
            if (vecs[i].gap[j] != 0) idle_cycles(int'(vecs[i].gap[j]));
         end
         wait_drain();
      end

      // Result held while the consumer stalls; in_valid held across handshake.
      exp_q.push_back(W'(30));
      out_ready = 1'b0;
      send_term(8'd3, 8'd5);
      send_term(8'd2, 8'd7);
      send_term(8'd1, 8'd1);
      send_term(8'd0, 8'd9);
      begin
         int n;
         n = 0;
         while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
         end
         check("done_reached", out_valid, 1);
      end
      repeat (3) begin
         @(negedge clk);
         check("stall_busy", busy, 1);
         check("stall_out_valid", out_valid, 1);
      end
      @(posedge clk);
      #1;
      exp_q.push_back(W'(4));
      out_ready = 1'b1;
      A = 8'd1;
      X = 8'd1;
      in_valid = 1'b1;
      @(negedge clk);
      check("hs_cycle_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("after_hs_in_ready", in_ready, 1);
      last_acc_cyc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      send_term(8'd1, 8'd1);
      send_term(8'd1, 8'd1);
      send_term(8'd1, 8'd1);
      wait_drain();

      // Reset in the middle of a batch discards the partial terms.
      send_term(8'd7, 8'd9);
      send_term(8'd5, 8'd5);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", busy, 0);
      check("midrst_state", dbg_state, 0);
      @(posedge clk);
      #1;
      exp_q.push_back(W'(16));
      repeat (4) send_term(8'd2, 8'd2);
      wait_drain();

      idle_cycles(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
